// File: rtl/umul_q_laccp_axis_if.sv
// Stream bundle for the LACCP fixed-point multiplier: operand/multiplier in, product out.
// The slave modport is the multiplier's view; master is the producer/consumer side.
interface umul_q_laccp_axis_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned QI = 16,
  parameter int unsigned QF = 8
) ();
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [QI-1:0]       s_axis_q_int;
  logic [QF-1:0]       s_axis_q_frac;
  logic [DW-1:0]       s_axis_multiplier;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [DW+QI-1:0]    m_axis_prod_int;
  logic [QF-1:0]       m_axis_prod_frac;
  logic                m_axis_zero;

  modport slave (
    input  s_axis_tvalid, s_axis_q_int, s_axis_q_frac, s_axis_multiplier, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_prod_int, m_axis_prod_frac, m_axis_zero
  );

  modport master (
    output s_axis_tvalid, s_axis_q_int, s_axis_q_frac, s_axis_multiplier, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_prod_int, m_axis_prod_frac, m_axis_zero
  );
endinterface

// File: rtl/umul_q_laccp_axis.sv
// Shift/add unsigned QI.QF x DW multiplier with constant DW-cycle latency and a
// 1-deep output hold register; rescales LACCP divider ratios back onto integer counts.
module umul_q_laccp_axis #(
  parameter int unsigned DW    = 16,
  parameter int unsigned QI    = 16,
  parameter int unsigned QF    = 8,
  parameter int unsigned ROUND = 0
) (
  input logic                 clk,
  input logic                 rst,
  umul_q_laccp_axis_if.slave  bus
);
  localparam int unsigned PW = DW + QI + QF;
  localparam int unsigned IW = DW + QI;
  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic          state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [DW-1:0] mplr;

  logic          out_valid;
  logic [IW-1:0] prod_int;
  logic [QF-1:0] prod_frac;
  logic          prod_zero;

  logic          in_ready;
  logic          in_fire;
  logic          out_fire;
  logic [PW-1:0] acc_next;
  logic          round_bit;
  logic [IW-1:0] int_next;

  assign in_ready = (state == StIdle) && !out_valid;
  assign in_fire  = bus.s_axis_tvalid && in_ready;
  assign out_fire = out_valid && bus.m_axis_tready;

  // acc_next includes the add of the current edge, so the final edge can
  // load the hold registers directly without an extra cycle.
  always_comb begin
    acc_next  = mplr[0] ? (acc + mcand) : acc;
    round_bit = (ROUND != 0) ? acc_next[QF-1] : 1'b0;
    int_next  = acc_next[PW-1:QF] + IW'(round_bit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      out_valid <= 1'b0;
      prod_int  <= '0;
      prod_frac <= '0;
      prod_zero <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (in_fire) begin
            mcand <= PW'({bus.s_axis_q_int, bus.s_axis_q_frac});
            mplr  <= bus.s_axis_multiplier;
            acc   <= '0;
            cnt   <= CW'(DW);
            state <= StRun;
          end
        end
        StRun: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_valid <= 1'b1;
            prod_int  <= int_next;
            prod_frac <= acc_next[QF-1:0];
            prod_zero <= (acc_next == '0);
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.s_axis_tready    = in_ready;
  assign bus.m_axis_tvalid    = out_valid;
  assign bus.m_axis_prod_int  = prod_int;
  assign bus.m_axis_prod_frac = prod_frac;
  assign bus.m_axis_zero      = prod_zero;
endmodule

// File: tb/tb_umul_q_laccp_axis.sv
// Scoreboard bench: a truncating and a rounding instance run in lockstep on the same stimulus.
module tb_umul_q_laccp_axis;
  localparam int unsigned DW = 16;
  localparam int unsigned QI = 16;
  localparam int unsigned QF = 8;
  localparam int unsigned PW = DW + QI + QF;
  localparam int unsigned IW = DW + QI;

  typedef struct packed {
    logic [IW-1:0] pint_t;
    logic [IW-1:0] pint_r;
    logic [QF-1:0] pfrac;
    logic          zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  umul_q_laccp_axis_if #(.DW(DW), .QI(QI), .QF(QF)) bus0 ();
  umul_q_laccp_axis_if #(.DW(DW), .QI(QI), .QF(QF)) bus1 ();

  umul_q_laccp_axis #(.DW(DW), .QI(QI), .QF(QF), .ROUND(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  umul_q_laccp_axis #(.DW(DW), .QI(QI), .QF(QF), .ROUND(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic drive_in(input logic v, input logic [QI-1:0] qi, input logic [QF-1:0] qf,
                          input logic [DW-1:0] m);
    bus0.s_axis_tvalid = v;  bus1.s_axis_tvalid = v;
    bus0.s_axis_q_int  = qi; bus1.s_axis_q_int  = qi;
    bus0.s_axis_q_frac = qf; bus1.s_axis_q_frac = qf;
    bus0.s_axis_multiplier = m; bus1.s_axis_multiplier = m;
  endtask

  task automatic set_mready(input logic r);
    bus0.m_axis_tready = r;
    bus1.m_axis_tready = r;
  endtask

  function automatic exp_t model(input logic [QI-1:0] qi, input logic [QF-1:0] qf,
                                 input logic [DW-1:0] m);
    exp_t e;
    logic [PW-1:0] p;
    p        = PW'({qi, qf}) * PW'(m);
    e.pint_t = p[PW-1:QF];
    e.pint_r = p[PW-1:QF] + IW'(p[QF-1]);
    e.pfrac  = p[QF-1:0];
    e.zero   = (p == '0);
    return e;
  endfunction

  // Presents a job, waits for acceptance, then scrambles the input bus.
  task automatic send(input logic [QI-1:0] qi, input logic [QF-1:0] qf, input logic [DW-1:0] m);
    int n = 0;
    @(negedge clk);
    drive_in(1'b1, qi, qf, m);
    while (!bus0.s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_axis_tready stayed %b, want 1", bus0.s_axis_tready);
    end
    @(posedge clk);
    sb.push_back(model(qi, qf, m));
    #1;
    drive_in(1'b0, QI'($urandom), QF'($urandom), DW'($urandom));
  endtask

  task automatic collect_result(output exp_t e);
    int n = 0;
    e = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.m_axis_tvalid && n < DW + 4);
    checks++;
    if (n != DW + 1) begin
      errors++;
      $display("FAIL latency: tvalid after %0d edges, want %0d", n - 1, DW);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: result with empty queue, got int=%h want none",
               bus0.m_axis_prod_int);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus1.m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL tvalid_round: got %b want 1", bus1.m_axis_tvalid);
    end
    checks++;
    if (bus0.m_axis_prod_int !== e.pint_t) begin
      errors++; $display("FAIL prod_int_trunc: got %h want %h", bus0.m_axis_prod_int, e.pint_t);
    end
    checks++;
    if (bus1.m_axis_prod_int !== e.pint_r) begin
      errors++; $display("FAIL prod_int_round: got %h want %h", bus1.m_axis_prod_int, e.pint_r);
    end
    checks++;
    if (bus0.m_axis_prod_frac !== e.pfrac || bus1.m_axis_prod_frac !== e.pfrac) begin
      errors++;
      $display("FAIL prod_frac: got %h/%h want %h", bus0.m_axis_prod_frac,
               bus1.m_axis_prod_frac, e.pfrac);
    end
    checks++;
    if (bus0.m_axis_zero !== e.zero || bus1.m_axis_zero !== e.zero) begin
      errors++;
      $display("FAIL zero: got %b/%b want %b", bus0.m_axis_zero, bus1.m_axis_zero, e.zero);
    end
  endtask

  task automatic expect_drained();
    @(negedge clk);
    checks++;
    if (bus0.m_axis_tvalid !== 1'b0 || bus0.s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL drain: tvalid=%b tready=%b want 0/1", bus0.m_axis_tvalid,
               bus0.s_axis_tready);
    end
  endtask

  task automatic test_reset();
    drive_in(1'b0, '0, '0, '0);
    set_mready(1'b1);
    #1;
    checks++;
    if (bus0.m_axis_tvalid !== 1'b0 || bus0.m_axis_prod_int !== '0 ||
        bus0.m_axis_prod_frac !== '0 || bus0.m_axis_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b int=%h frac=%h z=%b want all 0",
               bus0.m_axis_tvalid, bus0.m_axis_prod_int, bus0.m_axis_prod_frac,
               bus0.m_axis_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.s_axis_tready !== 1'b1 || bus1.s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready: got %b want 1", bus0.s_axis_tready);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    send(16'd1, 8'h80, 16'd1000);
    collect_result(e);
    checks++;
    if (bus0.m_axis_prod_int !== 32'd1500) begin
      errors++; $display("FAIL basic_const: got %0d want 1500", bus0.m_axis_prod_int);
    end
    expect_drained();
    send(16'd3, 8'h55, 16'd300);
    collect_result(e);
    checks++;
    if (bus0.m_axis_prod_int !== 32'd999 || bus1.m_axis_prod_int !== 32'd1000 ||
        bus0.m_axis_prod_frac !== 8'h9C) begin
      errors++;
      $display("FAIL round_const: got %0d/%0d frac %h want 999/1000 frac 9c",
               bus0.m_axis_prod_int, bus1.m_axis_prod_int, bus0.m_axis_prod_frac);
    end
    expect_drained();
    send(16'hFFFF, 8'hFF, 16'hFFFF);
    collect_result(e);
    checks++;
    if (bus1.m_axis_prod_int !== 32'hFFFEFF00 || bus0.m_axis_prod_frac !== 8'h01) begin
      errors++;
      $display("FAIL all_ones_const: got %h frac %h want fffeff00 frac 01",
               bus1.m_axis_prod_int, bus0.m_axis_prod_frac);
    end
    expect_drained();
  endtask

  task automatic test_zero();
    exp_t e;
    send(16'h1234, 8'h56, 16'd0);
    collect_result(e);
    expect_drained();
    send(16'd0, 8'd0, 16'hBEEF);
    collect_result(e);
    expect_drained();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(QI'($urandom), QF'($urandom), DW'($urandom));
      collect_result(e);
      expect_drained();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic ok;
    exp_t eb;
    set_mready(1'b0);
    send(16'd77, 8'h3C, 16'd4321);
    collect_result(e);
    drive_in(1'b1, 16'd5, 8'hC0, 16'd999);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.m_axis_tvalid !== 1'b1 || bus0.s_axis_tready !== 1'b0 ||
          bus0.m_axis_prod_int !== e.pint_t || bus1.m_axis_prod_int !== e.pint_r ||
          bus0.m_axis_prod_frac !== e.pfrac || bus0.m_axis_zero !== e.zero) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_stable: v=%b tready=%b int=%h want v=1 tready=0 int=%h",
               bus0.m_axis_tvalid, bus0.s_axis_tready, bus0.m_axis_prod_int, e.pint_t);
    end
    set_mready(1'b1);
    @(negedge clk);
    checks++;
    if (bus0.m_axis_tvalid !== 1'b0 || bus0.s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL release: tvalid=%b tready=%b want 0/1", bus0.m_axis_tvalid,
               bus0.s_axis_tready);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL pending_count: got %0d want 0", sb.size());
    end
    @(posedge clk);
    eb = model(16'd5, 8'hC0, 16'd999);
    sb.push_back(eb);
    #1;
    drive_in(1'b0, '0, '0, '0);
    collect_result(e);
    expect_drained();
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    logic quiet;
    send(16'd9, 8'h11, 16'd12345);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus0.m_axis_prod_int !== '0 || bus1.m_axis_prod_int !== '0 ||
        bus0.m_axis_prod_frac !== '0 || bus0.m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got int=%h frac=%h v=%b want 0", bus0.m_axis_prod_int,
               bus0.m_axis_prod_frac, bus0.m_axis_tvalid);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < DW + 4; i++) begin
      @(negedge clk);
      if (bus0.m_axis_tvalid !== 1'b0 || bus1.m_axis_tvalid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL discarded_job: tvalid rose, want it to stay 0");
    end
    send(16'd2, 8'h40, 16'd600);
    collect_result(e);
    expect_drained();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
